// File: rtl/aximm_test0_burst_addr_gen.sv
// Splits an (base + offset, byte count) command into AXI4 burst requests that
// never exceed MAX_BEATS beats and never cross a 4 KB boundary.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high once reset has settled
// CALC  | size the next burst from cur_addr / rem_beats
// ISSUE | burst request presented, waiting for burst_ready
module aximm_test0_burst_addr_gen #(
    parameter int ADDR_WIDTH   = 64,
    parameter int OFFSET_WIDTH = 60,
    parameter int BYTES_WIDTH  = 32,
    parameter int DATA_BYTES   = 8,
    parameter int MAX_BEATS    = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_base,
    input  logic [OFFSET_WIDTH-1:0] cmd_offset,
    input  logic [BYTES_WIDTH-1:0]  cmd_bytes,
    output logic                    burst_valid,
    input  logic                    burst_ready,
    output logic [ADDR_WIDTH-1:0]   burst_addr,
    output logic [7:0]              burst_len,
    output logic                    burst_last,
    output logic                    done
);

    localparam int ALIGN = $clog2(DATA_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_BYTES - 1);

    typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [BYTES_WIDTH-1:0]  rem_beats;
    logic [8:0]              n_q;
    logic                    init_q;

    logic                    cmd_fire, burst_fire;
    logic [ADDR_WIDTH-1:0]   start_addr;
    logic [BYTES_WIDTH:0]    bytes_ext;
    logic [BYTES_WIDTH-1:0]  rem_init;
    logic [12:0]             room, b4k, n_calc;

    // cmd_ready stays low through the done pulse so commands never overlap
    assign cmd_ready   = (state == IDLE) && init_q && !done;
    assign burst_valid = (state == ISSUE);
    assign cmd_fire    = cmd_valid && cmd_ready && ce;
    assign burst_fire  = burst_valid && burst_ready && ce;

    assign start_addr = (cmd_base + ADDR_WIDTH'(cmd_offset)) & ALIGN_MASK;
    // one extra bit so the round-up of an all-ones byte count cannot wrap
    assign bytes_ext  = {1'b0, cmd_bytes} + (BYTES_WIDTH + 1)'(DATA_BYTES - 1);
    assign rem_init   = BYTES_WIDTH'(bytes_ext >> ALIGN);
    assign room       = 13'd4096 - {1'b0, cur_addr[11:0]};
    assign b4k        = room >> ALIGN;

    always_comb begin
        n_calc = 13'(MAX_BEATS);
        if (rem_beats < BYTES_WIDTH'(MAX_BEATS)) begin
            n_calc = 13'(rem_beats);
        end
        if (b4k < n_calc) begin
            n_calc = b4k;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire && (cmd_bytes != '0)) state_nxt = CALC;
            CALC:    state_nxt = ISSUE;
            ISSUE:   if (burst_fire) state_nxt = burst_last ? IDLE : CALC;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_q     <= 1'b0;
            cur_addr   <= '0;
            rem_beats  <= '0;
            n_q        <= '0;
            burst_addr <= '0;
            burst_len  <= '0;
            burst_last <= 1'b0;
            done       <= 1'b0;
        end else if (ce) begin
            init_q <= 1'b1;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        cur_addr  <= start_addr;
                        rem_beats <= rem_init;
                        done      <= (cmd_bytes == '0);
                    end
                end
                CALC: begin
                    burst_addr <= cur_addr;
                    burst_len  <= 8'(n_calc - 13'd1);
                    burst_last <= (rem_beats == BYTES_WIDTH'(n_calc));
                    n_q        <= n_calc[8:0];
                end
                ISSUE: begin
                    if (burst_fire) begin
                        cur_addr  <= cur_addr + (ADDR_WIDTH'(n_q) << ALIGN);
                        rem_beats <= rem_beats - BYTES_WIDTH'(n_q);
                        done      <= burst_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aximm_test0_burst_addr_gen.sv
// Self-checking bench for aximm_test0_burst_addr_gen: directed vector table,
// hand-written reset/overflow sequences, and random commands vs. a burst-list model.
module tb_aximm_test0_burst_addr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_base;
    logic [59:0] cmd_offset;
    logic [31:0] cmd_bytes;
    logic        burst_valid;
    logic        burst_ready;
    logic [63:0] burst_addr;
    logic [7:0]  burst_len;
    logic        burst_last;
    logic        done;

    int checks = 0;
    int errors = 0;

    aximm_test0_burst_addr_gen dut (
        .clk(clk), .reset(reset), .ce(ce),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_offset(cmd_offset), .cmd_bytes(cmd_bytes),
        .burst_valid(burst_valid), .burst_ready(burst_ready),
        .burst_addr(burst_addr), .burst_len(burst_len),
        .burst_last(burst_last), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic        last;
    } burst_t;

    typedef struct {
        logic [63:0] base;
        logic [59:0] off;
        logic [31:0] bytes;
        int          bp;
        int          ce_off;
        int          nb;
        logic [63:0] a0; logic [7:0] l0; logic z0;
        logic [63:0] a1; logic [7:0] l1; logic z1;
    } vec_t;

    burst_t exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected burst list straight from the splitting rules, in plain arithmetic.
    function automatic void build_exp(input logic [63:0] base, input logic [59:0] off,
                                      input logic [31:0] bytes);
        longint unsigned addr, beats, room, n;
        burst_t b;
        exp_q.delete();
        addr  = (base + 64'(off)) & ~64'd7;
        beats = (longint'(bytes) + 7) / 8;
        while (beats > 0) begin
            room = (4096 - (addr % 4096)) / 8;
            n = beats;
            if (n > 256) n = 256;
            if (n > room) n = room;
            b.addr = addr;
            b.len  = 8'(n - 1);
            b.last = (n == beats);
            exp_q.push_back(b);
            addr  = addr + n * 8;
            beats = beats - n;
        end
    endfunction

    task automatic chk_fields(input string tag, input burst_t b);
        chk({tag, " burst_valid"}, burst_valid, 1'b1);
        chk({tag, " burst_addr"}, burst_addr, b.addr);
        chk({tag, " burst_len"}, burst_len, b.len);
        chk({tag, " burst_last"}, burst_last, b.last);
    endtask

    // Drives one command and checks the burst sequence held in exp_q.
    task automatic run_cmd(input string tag, input logic [63:0] base, input logic [59:0] off,
                           input logic [31:0] bytes, input int bp, input int ce_off);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        chk({tag, " cmd_ready idle"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_base = base; cmd_offset = off; cmd_bytes = bytes;
        tick();
        cmd_valid = 1'b0;
        chk({tag, " no valid at accept+1"}, burst_valid, 1'b0);
        if (exp_q.size() == 0) begin
            chk({tag, " zero-byte done"}, done, 1'b1);
            chk({tag, " ready low in done"}, cmd_ready, 1'b0);
            tick();
            chk({tag, " done cleared"}, done, 1'b0);
            chk({tag, " no burst"}, burst_valid, 1'b0);
            chk({tag, " ready back"}, cmd_ready, 1'b1);
            return;
        end
        foreach (exp_q[i]) begin
            tick();
            n = 1;
            while (!burst_valid && n < 20) begin tick(); n++; end
            chk({tag, " burst spacing"}, 64'(n), 64'd1);
            chk_fields(tag, exp_q[i]);
            if (i == 0) begin
                for (int k = 0; k < bp; k++) begin
                    tick();
                    chk_fields({tag, " backpressure"}, exp_q[i]);
                end
                ce = 1'b0;
                burst_ready = 1'b1;
                for (int k = 0; k < ce_off; k++) begin
                    tick();
                    chk_fields({tag, " ce low"}, exp_q[i]);
                    chk({tag, " ce low done"}, done, 1'b0);
                end
                ce = 1'b1;
            end
            burst_ready = 1'b1;
            tick();
            burst_ready = 1'b0;
            chk({tag, " valid drops"}, burst_valid, 1'b0);
            chk({tag, " done pulse"}, done, exp_q[i].last);
        end
        chk({tag, " ready low in done"}, cmd_ready, 1'b0);
        tick();
        chk({tag, " done cleared"}, done, 1'b0);
        chk({tag, " ready back"}, cmd_ready, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " cmd_ready"}, cmd_ready, 1'b0);
        chk({tag, " burst_valid"}, burst_valid, 1'b0);
        chk({tag, " burst_addr"}, burst_addr, 64'd0);
        chk({tag, " burst_len"}, burst_len, 8'd0);
        chk({tag, " burst_last"}, burst_last, 1'b0);
        chk({tag, " done"}, done, 1'b0);
    endtask

    // Accepts a command, takes two bursts, then resets while the second is pending.
    task automatic reset_mid_cmd(input string tag, input logic [63:0] base, input logic [31:0] bytes,
                                 input burst_t b0, input burst_t b1);
        int seen;
        cmd_valid = 1'b1; cmd_base = base; cmd_offset = '0; cmd_bytes = bytes;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk_fields({tag, " first"}, b0);
        burst_ready = 1'b1;
        tick();
        burst_ready = 1'b0;
        tick();
        chk_fields({tag, " second"}, b1);
        #2 reset = 1'b0;
        #1 chk_reset_outputs({tag, " async reset"});
        tick();
        tick();
        reset = 1'b1;
        seen = 0;
        burst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (burst_valid) seen++;
        end
        burst_ready = 1'b0;
        chk({tag, " no burst after reset"}, 64'(seen), 64'd0);
    endtask

    vec_t vecs[7];

    initial begin
        burst_t b0, b1;
        logic [31:0] r0, r1, r2;
        vecs[0] = '{64'h1000, 60'h0, 32'd64, 0, 0, 1, 64'h1000, 8'd7, 1'b1, 64'h0, 8'd0, 1'b0};
        vecs[1] = '{64'h0, 60'hFC0, 32'd128, 0, 0, 2, 64'hFC0, 8'd7, 1'b0, 64'h1000, 8'd7, 1'b1};
        vecs[2] = '{64'h2000, 60'h0, 32'd4096, 0, 0, 2, 64'h2000, 8'd255, 1'b0, 64'h2800, 8'd255, 1'b1};
        vecs[3] = '{64'h10, 60'h5, 32'd20, 0, 0, 1, 64'h10, 8'd2, 1'b1, 64'h0, 8'd0, 1'b0};
        vecs[4] = '{64'h1234, 60'h0, 32'd0, 0, 0, 0, 64'h0, 8'd0, 1'b0, 64'h0, 8'd0, 1'b0};
        vecs[5] = '{64'h0, 60'hFC0, 32'd128, 5, 3, 2, 64'hFC0, 8'd7, 1'b0, 64'h1000, 8'd7, 1'b1};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FF00, 60'h0, 32'd512, 0, 0, 2,
                    64'hFFFF_FFFF_FFFF_FF00, 8'd31, 1'b0, 64'h0, 8'd31, 1'b1};

        reset = 1'b0; ce = 1'b1; cmd_valid = 1'b0; burst_ready = 1'b0;
        cmd_base = '0; cmd_offset = '0; cmd_bytes = '0;
        tick();
        tick();
        chk_reset_outputs("reset");
        reset = 1'b1;
        tick();
        chk("ready after reset", cmd_ready, 1'b1);

        foreach (vecs[v]) begin
            exp_q.delete();
            if (vecs[v].nb > 0) begin
                b0.addr = vecs[v].a0; b0.len = vecs[v].l0; b0.last = vecs[v].z0;
                exp_q.push_back(b0);
            end
            if (vecs[v].nb > 1) begin
                b1.addr = vecs[v].a1; b1.len = vecs[v].l1; b1.last = vecs[v].z1;
                exp_q.push_back(b1);
            end
            run_cmd($sformatf("vec%0d", v), vecs[v].base, vecs[v].off, vecs[v].bytes,
                    vecs[v].bp, vecs[v].ce_off);
        end

        b0 = '{64'h0, 8'd255, 1'b0};
        b1 = '{64'h800, 8'd255, 1'b0};
        reset_mid_cmd("maxbytes", 64'h0, 32'hFFFF_FFFF, b0, b1);

        b0 = '{64'h2000, 8'd255, 1'b0};
        b1 = '{64'h2800, 8'd255, 1'b1};
        reset_mid_cmd("reset3", 64'h2000, 32'd4096, b0, b1);

        build_exp(64'h1000, 60'h0, 32'd64);
        run_cmd("post-reset", 64'h1000, 60'h0, 32'd64, 0, 0);

        for (int t = 0; t < 40; t++) begin
            logic [63:0] base;
            logic [59:0] off;
            logic [31:0] bytes;
            r0 = $urandom; r1 = $urandom; r2 = $urandom;
            base  = {r0, r1};
            r0 = $urandom;
            off   = {r0[27:0], r2};
            bytes = (t % 8 == 0) ? 32'($urandom_range(0, 16)) : 32'($urandom_range(1, 6000));
            build_exp(base, off, bytes);
            run_cmd($sformatf("rand%0d", t), base, off, bytes,
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
